// File: rtl/alu_mul_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer_pkg
// Shared ALU definitions for the execute stage: ALU control encodings and the
// state encoding of the shift-and-add multiply sequencer.
// -----------------------------------------------------------------------------
package alu_mul_sequencer_pkg;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD = 3'b000;
  localparam alu_ctrl_t ALU_SUB = 3'b001;
  localparam alu_ctrl_t ALU_AND = 3'b010;
  localparam alu_ctrl_t ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
// Computes the low WIDTH bits of op_a*op_b by driving the shared ALU with ADD
// only, one shift-and-add step per cycle. While busy it owns the ALU operand
// mux (alu_req). The loop stops as soon as the remaining multiplier is zero,
// so latency tracks the highest set bit of op_b.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start, op_a, op_b   request and operands, captured when not busy
//   alu_req             ALU ownership request (high in RUN)
//   alu_a, alu_b        ALU operands: accumulator, shifted multiplicand
//   alu_control         ALU operation, always ADD
//   alu_result          combinational ALU result for alu_a/alu_b
//   busy                high while iterating
//   done                one-cycle pulse, product valid
//   product             result, held until the next accepted start
// -----------------------------------------------------------------------------
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    unique case (state_q)
      IDLE, DONE: begin
        // A start in DONE is accepted, allowing back-to-back multiplies.
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // No multiplier bits left: the accumulator already holds the product.
        if (mplier_q == '0) begin
          state_d = DONE;
        end else begin
          if (mplier_q[0]) acc_d = alu_result;
          // Carry-out and bits shifted past the MSB are dropped: the result
          // is modulo 2^WIDTH, identical for signed and unsigned operands.
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values computed before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign alu_a       = acc_q;
  assign alu_b       = mcand_q;
  assign alu_control = ALU_ADD;
  assign alu_req     = (state_q == RUN);
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign product     = acc_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_sequencer
// Scoreboard bench: the driver pushes the expected product and done cycle for
// every accepted start; a monitor pops and compares whenever done is seen.
// A tiny ALU model closes the alu_a/alu_b/alu_control -> alu_result loop.
// -----------------------------------------------------------------------------
module tb_alu_mul_sequencer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] op_a, op_b;
  logic             alu_req;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             busy, done;
  logic [WIDTH-1:0] product;

  alu_mul_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .alu_req     (alu_req),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  // Shared ALU model.
  always_comb begin
    case (alu_control)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    logic [WIDTH-1:0] prod;
    int               done_cycle;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] last_prod = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: full-width product truncated, latency from highest set bit.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int e0);
    exp_t        e;
    logic [63:0] full;
    int          k;
    full = 64'(a) * 64'(b);
    k = -1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) k = i;
    e.prod       = full[WIDTH-1:0];
    e.done_cycle = e0 + k + 2;
    return e;
  endfunction

  // Called on a negedge with the DUT not busy; the next posedge accepts.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sb.push_back(model(a, b, cycle_cnt + 1));
    @(negedge clk);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(done), 64'(1));
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_prod = '0;
      end else begin
        if (alu_req) check("alu_control", 64'(alu_control), 64'(3'b000));
        check("busy_eq_req", 64'(busy), 64'(alu_req));
        if (done) begin
          if (sb.size() == 0) begin
            check("spurious_done", 64'(done), 64'(0));
          end else begin
            e = sb.pop_front();
            check("product", 64'(product), 64'(e.prod));
            check("done_cycle", 64'(cycle_cnt), 64'(e.done_cycle));
            last_prod = e.prod;
          end
        end else if (!busy) begin
          check("product_hold", 64'(product), 64'(last_prod));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #1;
    check("rst_busy",    64'(busy),    64'(0));
    check("rst_done",    64'(done),    64'(0));
    check("rst_alu_req", 64'(alu_req), 64'(0));
    check("rst_product", 64'(product), 64'(0));
    check("rst_alu_a",   64'(alu_a),   64'(0));
    check("rst_alu_b",   64'(alu_b),   64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    issue(32'd3, 32'd5);              wait_idle();
    issue(32'd7, 32'd0);              wait_idle();
    issue(32'd0, 32'h8000_0000);      wait_idle();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    issue(32'hFFFF_FFFE, 32'd3);      wait_idle();

    // Start while busy is ignored; start during DONE is accepted.
    issue(32'd3, 32'd5);
    start = 1'b1; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(32'd6, 32'd7);
    wait_idle();

    // Asynchronous reset between edges aborts the run.
    issue(32'h1234, 32'h10);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_busy",    64'(busy),    64'(0));
    check("abort_done",    64'(done),    64'(0));
    check("abort_alu_req", 64'(alu_req), 64'(0));
    check("abort_product", 64'(product), 64'(0));
    sb.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    issue(32'd2, 32'd2);
    wait_idle();

    // Random operands, with varied multiplier lengths and idle gaps.
    for (int i = 0; i < 1000; i++) begin
      logic [WIDTH-1:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 32);
      if ($urandom_range(0, 15) == 0) b = '0;
      issue(a, b);
      wait_idle();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
